// File: rtl/mont_mult_if.sv
// mont_mult_if
// Request/response bundle for the Montgomery multiplier.
//   start     : request, sampled only while the multiplier is idle
//   A, B, N   : multiplicand, multiplier, odd modulus (A < N, B < N)
//   R         : result A*B*2^(-WIDTH) mod N, held until the next completion
//   busy      : operation in progress
//   done      : one-cycle completion pulse
//   err       : even-modulus flag (only meaningful with MONT_ODD_CHECK_EN)
// Modports: master (requester side), slave (multiplier side).
interface mont_mult_if #(
  parameter int WIDTH = 1024
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] N;
  logic [WIDTH-1:0] R;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, A, B, N,
    input  R, busy, done, err
  );

  modport slave (
    input  start, A, B, N,
    output R, busy, done, err
  );
endinterface

// File: rtl/mont_mult.sv
// mont_mult
// Bit-serial radix-2 Montgomery modular multiplier: R = A*B*2^(-WIDTH) mod N.
// One multiplier bit is consumed per clock; an operation takes WIDTH CALC
// cycles plus one FIX cycle for the final conditional subtraction.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   bus    : mont_mult_if.slave (start, A, B, N in; R, busy, done, err out)
// Parameters:
//   WIDTH  : operand/modulus width, also the Montgomery exponent (r = 2^WIDTH)
//   CNT_W  : iteration counter width, 2^CNT_W must exceed WIDTH
// Build option:
//   MONT_ODD_CHECK_EN : when defined, an even modulus forces R=0 and pulses
//                       err together with done; otherwise err is tied low.
module mont_mult #(
  parameter int WIDTH = 1024,
  parameter int CNT_W = 11
) (
  input  logic       clk,
  input  logic       rst_n,
  mont_mult_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH-1:0] n_reg, n_next;
  logic [WIDTH-1:0] r_reg, r_next;
  logic [WIDTH+1:0] s_reg, s_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             done_reg, done_next;
  logic             err_reg, err_next;

  // Per-iteration datapath. The multiplicand is shifted right each cycle so
  // the current bit a_i is always a_reg[0]. Two guard bits keep S < 2N and
  // the intermediate sums below 4N without overflow.
  logic [WIDTH+1:0] s1;
  logic [WIDTH+1:0] s2;
  logic [WIDTH+1:0] n_ext;

  always_comb begin
    n_ext = {2'b00, n_reg};
    s1    = s_reg + (a_reg[0] ? {2'b00, b_reg} : '0);
    // Adding N when S1 is odd makes the sum even, so the shift is exact.
    s2    = s1 + (s1[0] ? n_ext : '0);
  end

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    n_next     = n_reg;
    r_next     = r_reg;
    s_next     = s_reg;
    cnt_next   = cnt_reg;
    done_next  = 1'b0;
    err_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          a_next     = bus.A;
          b_next     = bus.B;
          n_next     = bus.N;
          s_next     = '0;
          cnt_next   = '0;
          state_next = CALC;
        end
      end

      CALC: begin
        s_next   = s2 >> 1;
        a_next   = a_reg >> 1;
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == LAST_ITER) begin
          state_next = FIX;
        end
      end

      FIX: begin
        // S < 2N, so one conditional subtraction fully reduces it.
        if (s_reg >= n_ext) begin
          r_next = WIDTH'(s_reg - n_ext);
        end else begin
          r_next = WIDTH'(s_reg);
        end
`ifdef MONT_ODD_CHECK_EN
        if (!n_reg[0]) begin
          r_next   = '0;
          err_next = 1'b1;
        end
`endif
        done_next  = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      n_reg     <= '0;
      r_reg     <= '0;
      s_reg     <= '0;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      n_reg     <= n_next;
      r_reg     <= r_next;
      s_reg     <= s_next;
      cnt_reg   <= cnt_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  assign bus.R    = r_reg;
  assign bus.busy = (state_reg != IDLE);
  assign bus.done = done_reg;
  assign bus.err  = err_reg;

endmodule

// File: tb/tb_mont_mult.sv
// tb_mont_mult
// Directed bench for mont_mult at WIDTH=8, N=13 (2^-8 mod 13 = 3).
// Expected results are hand-computed: R = A*B*3 mod 13.
module tb_mont_mult;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mont_mult_if #(.WIDTH(W)) bus ();

  mont_mult #(.WIDTH(W), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Presents operands and pulses start across one rising edge (E0).
  // Returns at the falling edge following E0.
  task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] n);
    @(negedge clk);
    bus.A     = a;
    bus.B     = b;
    bus.N     = n;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Counts falling edges until done is seen (bounded), and how many of them
  // had busy high before done appeared.
  task automatic wait_done(output int cycles, output int busy_cycles,
                           output bit seen);
    cycles      = 0;
    busy_cycles = 0;
    seen        = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy === 1'b1) busy_cycles++;
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.N     = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.R !== 8'd0) begin
      errors++; $display("FAIL reset_R got=%0d want=0", bus.R);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got=%b want=0", bus.busy);
    end
    checks++;
    if (bus.done !== 1'b0) begin
      errors++; $display("FAIL reset_done got=%b want=0", bus.done);
    end
    checks++;
    if (bus.err !== 1'b0) begin
      errors++; $display("FAIL reset_err got=%b want=0", bus.err);
    end
    rst_n = 1'b1;
    $display("reset: R=%0d busy=%b done=%b err=%b", bus.R, bus.busy, bus.done, bus.err);
  endtask

  task automatic test_basic();
    int cyc, bcyc;
    bit seen;
    do_start(8'd5, 8'd7, 8'd13);
    wait_done(cyc, bcyc, seen);
    $display("basic: A=5 B=7 N=13 R=%0d cycles=%0d busy_cycles=%0d", bus.R, cyc, bcyc);
    checks++;
    if (!seen) begin
      errors++; $display("FAIL basic_timeout got=no_done want=done");
    end
    checks++;
    if (cyc != 9) begin
      errors++; $display("FAIL basic_latency got=%0d want=9", cyc);
    end
    checks++;
    if (bcyc != 9) begin
      errors++; $display("FAIL basic_busy_cycles got=%0d want=9", bcyc);
    end
    checks++;
    if (bus.R !== 8'd1) begin
      errors++; $display("FAIL basic_R got=%0d want=1", bus.R);
    end
    checks++;
    if (bus.err !== 1'b0) begin
      errors++; $display("FAIL basic_err got=%b want=0", bus.err);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0) begin
      errors++; $display("FAIL basic_done_width got=%b want=0", bus.done);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL basic_busy_after got=%b want=0", bus.busy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.R !== 8'd1) begin
      errors++; $display("FAIL basic_R_hold got=%0d want=1", bus.R);
    end
  endtask

  task automatic test_vectors();
    logic [W-1:0] va [6] = '{8'd1, 8'd12, 8'd0, 8'd9, 8'd2, 8'd12};
    logic [W-1:0] vb [6] = '{8'd1, 8'd12, 8'd9, 8'd0, 8'd3, 8'd1};
    logic [W-1:0] vr [6] = '{8'd3, 8'd3,  8'd0, 8'd0, 8'd5, 8'd10};
    int cyc, bcyc;
    bit seen;
    for (int i = 0; i < 6; i++) begin
      do_start(va[i], vb[i], 8'd13);
      wait_done(cyc, bcyc, seen);
      $display("vector %0d: A=%0d B=%0d N=13 R=%0d want=%0d cycles=%0d",
               i, va[i], vb[i], bus.R, vr[i], cyc);
      checks++;
      if (!seen || cyc != 9) begin
        errors++; $display("FAIL vec%0d_latency got=%0d want=9", i, cyc);
      end
      checks++;
      if (bus.R !== vr[i]) begin
        errors++; $display("FAIL vec%0d_R got=%0d want=%0d", i, bus.R, vr[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] va [4] = '{8'd1, 8'd12, 8'd0, 8'd5};
    logic [W-1:0] vb [4] = '{8'd1, 8'd12, 8'd9, 8'd7};
    logic [W-1:0] vr [4] = '{8'd3, 8'd3,  8'd0, 8'd1};
    int cyc, bcyc;
    bit seen;
    @(negedge clk);
    bus.A     = va[0];
    bus.B     = vb[0];
    bus.N     = 8'd13;
    bus.start = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      wait_done(cyc, bcyc, seen);
      $display("b2b %0d: A=%0d B=%0d N=13 R=%0d want=%0d cycles=%0d",
               i, va[i], vb[i], bus.R, vr[i], cyc);
      checks++;
      if (!seen || cyc != 9) begin
        errors++; $display("FAIL b2b%0d_latency got=%0d want=9", i, cyc);
      end
      checks++;
      if (bus.R !== vr[i]) begin
        errors++; $display("FAIL b2b%0d_R got=%0d want=%0d", i, bus.R, vr[i]);
      end
      if (i < 3) begin
        bus.A = va[i+1];
        bus.B = vb[i+1];
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0) begin
        errors++; $display("FAIL b2b%0d_done_width got=%b want=0", i, bus.done);
      end
      checks++;
      if (bus.busy !== (i < 3)) begin
        errors++; $display("FAIL b2b%0d_busy_restart got=%b want=%b", i, bus.busy, (i < 3));
      end
    end
  endtask

  task automatic test_start_while_busy();
    int cyc, bcyc;
    bit seen;
    bit restarted;
    do_start(8'd5, 8'd7, 8'd13);
    repeat (3) @(negedge clk);
    bus.A     = 8'd1;
    bus.B     = 8'd1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(cyc, bcyc, seen);
    $display("start_while_busy: R=%0d cycles_after_pulse=%0d", bus.R, cyc);
    checks++;
    if (!seen || cyc != 5) begin
      errors++; $display("FAIL swb_latency got=%0d want=5", cyc);
    end
    checks++;
    if (bus.R !== 8'd1) begin
      errors++; $display("FAIL swb_R got=%0d want=1", bus.R);
    end
    restarted = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.busy !== 1'b0) restarted = 1'b1;
    end
    checks++;
    if (restarted) begin
      errors++; $display("FAIL swb_queued got=busy want=idle");
    end
  endtask

  task automatic test_reset_mid_op();
    int cyc, bcyc;
    bit seen;
    bit spurious;
    do_start(8'd5, 8'd7, 8'd13);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    $display("reset_mid_op: busy=%b R=%0d done=%b", bus.busy, bus.R, bus.done);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL rmid_busy got=%b want=0", bus.busy);
    end
    checks++;
    if (bus.R !== 8'd0) begin
      errors++; $display("FAIL rmid_R got=%0d want=0", bus.R);
    end
    rst_n    = 1'b1;
    spurious = (bus.done !== 1'b0);
    repeat (12) begin
      @(negedge clk);
      if (bus.done !== 1'b0) spurious = 1'b1;
    end
    checks++;
    if (spurious) begin
      errors++; $display("FAIL rmid_done got=pulse want=none");
    end
    do_start(8'd5, 8'd7, 8'd13);
    wait_done(cyc, bcyc, seen);
    $display("after_reset: A=5 B=7 N=13 R=%0d cycles=%0d", bus.R, cyc);
    checks++;
    if (!seen || cyc != 9) begin
      errors++; $display("FAIL rmid_relatency got=%0d want=9", cyc);
    end
    checks++;
    if (bus.R !== 8'd1) begin
      errors++; $display("FAIL rmid_reR got=%0d want=1", bus.R);
    end
    @(negedge clk);
  endtask

  task automatic test_odd_check();
    int cyc, bcyc;
    bit seen;
    do_start(8'd5, 8'd7, 8'd12);
    wait_done(cyc, bcyc, seen);
    $display("even_N: A=5 B=7 N=12 R=%0d err=%b cycles=%0d", bus.R, bus.err, cyc);
    checks++;
    if (!seen || cyc != 9) begin
      errors++; $display("FAIL odd_latency got=%0d want=9", cyc);
    end
`ifdef MONT_ODD_CHECK_EN
    checks++;
    if (bus.err !== 1'b1) begin
      errors++; $display("FAIL odd_err got=%b want=1", bus.err);
    end
    checks++;
    if (bus.R !== 8'd0) begin
      errors++; $display("FAIL odd_R got=%0d want=0", bus.R);
    end
    @(negedge clk);
    checks++;
    if (bus.err !== 1'b0) begin
      errors++; $display("FAIL odd_err_width got=%b want=0", bus.err);
    end
`else
    checks++;
    if (bus.err !== 1'b0) begin
      errors++; $display("FAIL odd_err_disabled got=%b want=0", bus.err);
    end
    @(negedge clk);
`endif
    do_start(8'd5, 8'd7, 8'd13);
    wait_done(cyc, bcyc, seen);
    $display("odd_N: A=5 B=7 N=13 R=%0d err=%b cycles=%0d", bus.R, bus.err, cyc);
    checks++;
    if (!seen || bus.err !== 1'b0) begin
      errors++; $display("FAIL odd_err_oddN got=%b want=0", bus.err);
    end
    checks++;
    if (bus.R !== 8'd1) begin
      errors++; $display("FAIL odd_R_oddN got=%0d want=1", bus.R);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_back_to_back();
    test_start_while_busy();
    test_reset_mid_op();
    test_odd_check();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
